// File: rtl/fios_operand_server.sv
// -----------------------------------------------------------------------------
// fios_operand_server
//
// Operand/result buffer for a word-serial FIOS Montgomery multiplier. The host
// loads operands A, B and modulus P (s words of 17 bits each) and starts an
// operation with go_i. The multiplier then consumes these operands:
//   - A as a sliding window of PE_NB words,
//   - B and P one word per fetch.
// It streams result words back into R. The host reads R through a port with
// one cycle of latency.
//
// Configuration macro: FIOS_SERVER_OVF_CHECK_EN
//   defined   : a result push beyond s words is dropped and sets a sticky err_o
//   undefined : err_o is tied 0; the result pointer wraps, so an extra push
//               overwrites R[0]
//
// Ports
//   clock_i, reset_i          clock; asynchronous active-high reset
//   wr_en_i/sel/addr/data     host operand write (sel 0=A 1=B 2=P 3=none),
//                             dropped while busy
//   go_i                      start one multiplication (sampled in IDLE only)
//   start_o                   one-cycle start pulse to the multiplier
//   a_o                       current A window, word k at [17k+16:17k]
//   a_shift_i                 advance the A window by PE_NB words
//   b_fetch_i, p_fetch_i      request the next B / P word
//   b_o, p_o                  fetched B / P words, registered
//   RES_push_i, RES_i         result word strobe and data
//   done_i                    multiplier completion pulse
//   rd_addr_i, rd_data_o      host result read, 1-cycle latency
//   busy_o, res_valid_o       status flags
//   err_o                     overflow error flag
// -----------------------------------------------------------------------------
module fios_operand_server #(
    parameter int s     = 8,
    parameter int PE_NB = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  wr_en_i,
    input  logic [1:0]            wr_sel_i,
    input  logic [$clog2(s)-1:0]  wr_addr_i,
    input  logic [16:0]           wr_data_i,
    input  logic                  go_i,
    output logic                  start_o,
    output logic [PE_NB*17-1:0]   a_o,
    input  logic                  a_shift_i,
    input  logic                  b_fetch_i,
    input  logic                  p_fetch_i,
    output logic [16:0]           b_o,
    output logic [16:0]           p_o,
    input  logic                  RES_push_i,
    input  logic [16:0]           RES_i,
    input  logic                  done_i,
    input  logic [$clog2(s)-1:0]  rd_addr_i,
    output logic [16:0]           rd_data_o,
    output logic                  busy_o,
    output logic                  res_valid_o,
    output logic                  err_o
);

    localparam int AW  = $clog2(s);
    // The window base must be able to reach past s without wrapping.
    localparam int ABW = $clog2(s + 2 * PE_NB) + 1;
    // The result pointer must be able to hold the value s.
    localparam int RW  = $clog2(s + 1);

    localparam logic [ABW-1:0] S_A    = ABW'(s);
    localparam logic [ABW-1:0] PE_A   = ABW'(PE_NB);
    localparam logic [AW-1:0]  S_LAST = AW'(s - 1);
`ifdef FIOS_SERVER_OVF_CHECK_EN
    localparam logic [RW-1:0]  S_R    = RW'(s);
`else
    localparam logic [RW-1:0]  S_R_LAST = RW'(s - 1);
`endif

    typedef enum logic [1:0] {IDLE, START, RUN, FIN} state_t;

    state_t             state_q, state_d;
    logic [ABW-1:0]     a_base_q, a_base_d;
    logic [AW-1:0]      b_ptr_q, b_ptr_d;
    logic [AW-1:0]      p_ptr_q, p_ptr_d;
    logic [RW-1:0]      r_ptr_q, r_ptr_d;
    logic [16:0]        b_q, b_d;
    logic [16:0]        p_q, p_d;
    logic [16:0]        rd_q, rd_d;
    logic               res_valid_q, res_valid_d;
    logic               r_wr;
    logic [AW-1:0]      r_widx;

    // Buffer storage is deliberately left out of reset.
    logic [16:0] a_mem_q [s];
    logic [16:0] b_mem_q [s];
    logic [16:0] p_mem_q [s];
    logic [16:0] r_mem_q [s];

    // -------------------------------------------------------------------------
    // Control state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            a_base_q    <= '0;
            b_ptr_q     <= '0;
            p_ptr_q     <= '0;
            r_ptr_q     <= '0;
            b_q         <= '0;
            p_q         <= '0;
            rd_q        <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_base_q    <= a_base_d;
            b_ptr_q     <= b_ptr_d;
            p_ptr_q     <= p_ptr_d;
            r_ptr_q     <= r_ptr_d;
            b_q         <= b_d;
            p_q         <= p_d;
            rd_q        <= rd_d;
            res_valid_q <= res_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        a_base_d    = a_base_q;
        b_ptr_d     = b_ptr_q;
        p_ptr_d     = p_ptr_q;
        r_ptr_d     = r_ptr_q;
        b_d         = b_q;
        p_d         = p_q;
        res_valid_d = res_valid_q;
        r_wr        = 1'b0;
        r_widx      = r_ptr_q[AW-1:0];
        rd_d        = r_mem_q[rd_addr_i];

        case (state_q)
            IDLE: begin
                if (go_i) state_d = START;
            end
            START: begin
                state_d     = RUN;
                a_base_d    = '0;
                b_ptr_d     = '0;
                p_ptr_d     = '0;
                r_ptr_d     = '0;
                res_valid_d = 1'b0;
            end
            RUN: begin
                // Once the window is fully past the operand, it stays there.
                // This keeps the base bounded, so it never wraps back.
                if (a_shift_i && (a_base_q < S_A)) a_base_d = a_base_q + PE_A;
                if (b_fetch_i) begin
                    b_d     = b_mem_q[b_ptr_q];
                    b_ptr_d = (b_ptr_q == S_LAST) ? '0 : b_ptr_q + 1'b1;
                end
                if (p_fetch_i) begin
                    p_d     = p_mem_q[p_ptr_q];
                    p_ptr_d = (p_ptr_q == S_LAST) ? '0 : p_ptr_q + 1'b1;
                end
                if (RES_push_i) begin
`ifdef FIOS_SERVER_OVF_CHECK_EN
                    if (r_ptr_q < S_R) begin
                        r_wr    = 1'b1;
                        r_ptr_d = r_ptr_q + 1'b1;
                    end
`else
                    r_wr    = 1'b1;
                    r_ptr_d = (r_ptr_q == S_R_LAST) ? '0 : r_ptr_q + 1'b1;
`endif
                end
                if (done_i) state_d = FIN;
            end
            FIN: begin
                res_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Overflow flag
    // -------------------------------------------------------------------------
`ifdef FIOS_SERVER_OVF_CHECK_EN
    logic err_q;
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)
            err_q <= 1'b0;
        else if (state_q == START)
            err_q <= 1'b0;
        else if ((state_q == RUN) && RES_push_i && !(r_ptr_q < S_R))
            err_q <= 1'b1;
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Buffer writes: host operands while idle, results from the multiplier
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (wr_en_i && !busy_o) begin
            case (wr_sel_i)
                2'd0:    a_mem_q[wr_addr_i] <= wr_data_i;
                2'd1:    b_mem_q[wr_addr_i] <= wr_data_i;
                2'd2:    p_mem_q[wr_addr_i] <= wr_data_i;
                default: ;
            endcase
        end
        if (r_wr) r_mem_q[r_widx] <= RES_i;
    end

    // -------------------------------------------------------------------------
    // A window: words past the end of the operand read as zero
    // -------------------------------------------------------------------------
    logic [ABW-1:0] a_idx;
    always_comb begin
        a_o   = '0;
        a_idx = '0;
        for (int k = 0; k < PE_NB; k++) begin
            a_idx = a_base_q + ABW'(k);
            if (a_idx < S_A) a_o[17*k +: 17] = a_mem_q[a_idx[AW-1:0]];
        end
    end

    assign start_o     = (state_q == START);
    assign busy_o      = (state_q != IDLE);
    assign res_valid_o = res_valid_q;
    assign b_o         = b_q;
    assign p_o         = p_q;
    assign rd_data_o   = rd_q;

endmodule

// File: tb/tb_fios_operand_server.sv
module tb_fios_operand_server;

    localparam int S  = 8;
    localparam int PE = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [1:0]        wr_sel;
    logic [2:0]        wr_addr;
    logic [16:0]       wr_data;
    logic              go;
    logic              start_o;
    logic [PE*17-1:0]  a_o;
    logic              a_shift, b_fetch, p_fetch;
    logic [16:0]       b_o, p_o;
    logic              res_push;
    logic [16:0]       res_d;
    logic              done;
    logic [2:0]        rd_addr;
    logic [16:0]       rd_data;
    logic              busy_o, res_valid_o, err_o;

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays plus fetch counters.
    logic [16:0] ma [S];
    logic [16:0] mb [S];
    logic [16:0] mp [S];
    logic [16:0] mr [S];
    logic [16:0] b_exp, p_exp;
    int          nb, np;

    fios_operand_server #(.s(S), .PE_NB(PE)) dut (
        .clock_i(clk), .reset_i(rst),
        .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .go_i(go), .start_o(start_o), .a_o(a_o),
        .a_shift_i(a_shift), .b_fetch_i(b_fetch), .p_fetch_i(p_fetch),
        .b_o(b_o), .p_o(p_o),
        .RES_push_i(res_push), .RES_i(res_d), .done_i(done),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .busy_o(busy_o), .res_valid_o(res_valid_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PE*17-1:0] window(int base);
        logic [PE*17-1:0] w;
        w = '0;
        for (int k = 0; k < PE; k++)
            if (base + k < S) w[17*k +: 17] = ma[base + k];
        return w;
    endfunction

    task automatic host_write(input logic [1:0] sel, input int addr, input logic [16:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 3'(addr); wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_run();
        go = 1'b1;
        tick();
        go = 1'b0;
        checks++;
        if (start_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++; $display("FAIL start_pulse got start=%b busy=%b want 1/1", start_o, busy_o);
        end
        tick();
        checks++;
        if (start_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++; $display("FAIL start_one_cycle got start=%b busy=%b want 0/1", start_o, busy_o);
        end
    endtask

    task automatic finish_run();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
    endtask

    task automatic b_pulse();
        b_fetch = 1'b1;
        tick();
        b_fetch = 1'b0;
        b_exp = mb[nb % S]; nb++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({start_o, busy_o, res_valid_o, err_o} !== 4'b0 || b_o !== 17'd0 ||
            p_o !== 17'd0 || rd_data !== 17'd0) begin
            errors++;
            $display("FAIL reset_state got st=%b bz=%b rv=%b er=%b b=%h p=%h rd=%h want all 0",
                     start_o, busy_o, res_valid_o, err_o, b_o, p_o, rd_data);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset got busy=%b want 0", busy_o);
        end
        b_exp = '0; p_exp = '0;
    endtask

    task automatic test_window();
        for (int i = 0; i < S; i++) begin
            ma[i] = 17'(i + 1);
            host_write(2'd0, i, ma[i]);
        end
        start_run();
        checks++;
        if (a_o !== {17'd4, 17'd3, 17'd2, 17'd1}) begin
            errors++; $display("FAIL window0 got %h want %h", a_o, {17'd4, 17'd3, 17'd2, 17'd1});
        end
        a_shift = 1'b1; tick(); a_shift = 1'b0;
        checks++;
        if (a_o !== {17'd8, 17'd7, 17'd6, 17'd5}) begin
            errors++; $display("FAIL window1 got %h want %h", a_o, {17'd8, 17'd7, 17'd6, 17'd5});
        end
        for (int j = 0; j < 3; j++) begin
            a_shift = 1'b1; tick(); a_shift = 1'b0;
            checks++;
            if (a_o !== '0) begin
                errors++; $display("FAIL window_past_end%0d got %h want 0", j, a_o);
            end
        end
        // Writes and go while busy are dropped.
        host_write(2'd0, 0, 17'h1ABCD);
        go = 1'b1; tick(); go = 1'b0;
        checks++;
        if (start_o !== 1'b0) begin
            errors++; $display("FAIL go_ignored_in_run got start=%b want 0", start_o);
        end
        finish_run();
        // Random A contents, window model checked at each base.
        for (int i = 0; i < S; i++) begin
            ma[i] = 17'($urandom);
            host_write(2'd0, i, ma[i]);
        end
        start_run();
        for (int base = 0; base <= S; base += PE) begin
            checks++;
            if (a_o !== window(base)) begin
                errors++; $display("FAIL window_rand base=%0d got %h want %h", base, a_o, window(base));
            end
            a_shift = 1'b1; tick(); a_shift = 1'b0;
        end
        finish_run();
        start_run();
        checks++;
        if (a_o !== window(0)) begin
            errors++; $display("FAIL window_rewind got %h want %h", a_o, window(0));
        end
        finish_run();
    endtask

    task automatic test_fetch();
        for (int i = 0; i < S; i++) begin
            mb[i] = 17'(16 + i); mp[i] = 17'(32 + i);
            host_write(2'd1, i, mb[i]);
            host_write(2'd2, i, mp[i]);
        end
        // Fetch strobes in IDLE do nothing.
        b_fetch = 1'b1; p_fetch = 1'b1; tick(); b_fetch = 1'b0; p_fetch = 1'b0;
        checks++;
        if (b_o !== b_exp || p_o !== p_exp) begin
            errors++; $display("FAIL fetch_idle_ignored got b=%h p=%h want %h %h", b_o, p_o, b_exp, p_exp);
        end
        start_run();
        nb = 0; np = 0;
        for (int i = 0; i < 10; i++) begin
            b_pulse();
            checks++;
            if (b_o !== b_exp || p_o !== p_exp) begin
                errors++; $display("FAIL b_seq%0d got b=%h p=%h want %h %h", i, b_o, p_o, b_exp, p_exp);
            end
        end
        tick();
        checks++;
        if (b_o !== b_exp) begin
            errors++; $display("FAIL b_hold got %h want %h", b_o, b_exp);
        end
        b_fetch = 1'b1; p_fetch = 1'b1;
        for (int i = 0; i < S + 2; i++) begin
            tick();
            b_exp = mb[nb % S]; nb++;
            p_exp = mp[np % S]; np++;
            checks++;
            if (b_o !== b_exp || p_o !== p_exp) begin
                errors++; $display("FAIL lockstep%0d got b=%h p=%h want %h %h", i, b_o, p_o, b_exp, p_exp);
            end
        end
        b_fetch = 1'b0; p_fetch = 1'b0;
        finish_run();
        // Random contents and random request patterns.
        for (int i = 0; i < S; i++) begin
            mb[i] = 17'($urandom); mp[i] = 17'($urandom);
            host_write(2'd1, i, mb[i]);
            host_write(2'd2, i, mp[i]);
        end
        start_run();
        nb = 0; np = 0;
        for (int i = 0; i < 30; i++) begin
            b_fetch = 1'($urandom); p_fetch = 1'($urandom);
            tick();
            if (b_fetch) begin b_exp = mb[nb % S]; nb++; end
            if (p_fetch) begin p_exp = mp[np % S]; np++; end
            checks++;
            if (b_o !== b_exp || p_o !== p_exp) begin
                errors++; $display("FAIL fetch_rand%0d got b=%h p=%h want %h %h", i, b_o, p_o, b_exp, p_exp);
            end
        end
        b_fetch = 1'b0; p_fetch = 1'b0;
        finish_run();
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < S; i++) begin
            rd_addr = 3'(i);
            tick();
            checks++;
            if (rd_data !== mr[i]) begin
                errors++; $display("FAIL %s_rd%0d got %h want %h", tag, i, rd_data, mr[i]);
            end
        end
    endtask

    task automatic test_results();
        logic exp_err;
        int   n;
        start_run();
        checks++;
        if (res_valid_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL flags_in_run got rv=%b er=%b want 0/0", res_valid_o, err_o);
        end
        for (int i = 0; i < S; i++) begin
            res_push = 1'b1; res_d = 17'(8'hA0 + i); mr[i] = res_d;
            done = (i == S - 1);
            tick();
        end
        res_push = 1'b0; done = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || res_valid_o !== 1'b0) begin
            errors++; $display("FAIL fin_state got bz=%b rv=%b want 1/0", busy_o, res_valid_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0 || res_valid_o !== 1'b1 || err_o !== 1'b0) begin
            errors++; $display("FAIL res_valid got bz=%b rv=%b er=%b want 0/1/0", busy_o, res_valid_o, err_o);
        end
        rd_addr = 3'd7;
        tick();
        checks++;
        if (rd_data !== 17'h000A7) begin
            errors++; $display("FAIL rd7 got %h want 000a7", rd_data);
        end
        read_all("first");
        // A push in IDLE leaves R untouched.
        res_push = 1'b1; res_d = 17'h15555; tick(); res_push = 1'b0;
        read_all("idle_push");
        // Overflow run.
        start_run();
        checks++;
        if (res_valid_o !== 1'b0) begin
            errors++; $display("FAIL res_valid_cleared got %b want 0", res_valid_o);
        end
        for (int i = 0; i < S; i++) begin
            res_push = 1'b1; res_d = 17'($urandom); mr[i] = res_d;
            tick();
        end
        res_d = 17'h1FFFF;
        tick();
        res_push = 1'b0;
`ifdef FIOS_SERVER_OVF_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
        mr[0] = 17'h1FFFF;
`endif
        checks++;
        if (err_o !== exp_err) begin
            errors++; $display("FAIL overflow_err got %b want %b", err_o, exp_err);
        end
        finish_run();
        checks++;
        if (err_o !== exp_err || res_valid_o !== 1'b1) begin
            errors++; $display("FAIL err_sticky got er=%b rv=%b want %b/1", err_o, res_valid_o, exp_err);
        end
        read_all("ovf");
        // Random-length run; START clears the error.
        start_run();
        checks++;
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL err_cleared got %b want 0", err_o);
        end
        n = $urandom_range(1, S);
        for (int i = 0; i < n; i++) begin
            res_push = 1'b1; res_d = 17'($urandom); mr[i] = res_d;
            done = (i == n - 1);
            tick();
        end
        res_push = 1'b0; done = 1'b0;
        tick();
        read_all("rand");
    endtask

    task automatic test_reset_midrun();
        start_run();
        nb = 0;
        for (int i = 0; i < 3; i++) b_pulse();
        checks++;
        if (b_o !== mb[2]) begin
            errors++; $display("FAIL pre_reset_b got %h want %h", b_o, mb[2]);
        end
        rst = 1'b1;
        #2;
        checks++;
        if ({start_o, busy_o, res_valid_o, err_o} !== 4'b0 || b_o !== 17'd0 ||
            p_o !== 17'd0 || rd_data !== 17'd0) begin
            errors++;
            $display("FAIL async_reset got st=%b bz=%b rv=%b er=%b b=%h p=%h rd=%h want all 0",
                     start_o, busy_o, res_valid_o, err_o, b_o, p_o, rd_data);
        end
        go = 1'b1;
        tick(); tick();
        checks++;
        if (start_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL held_in_reset got st=%b bz=%b want 0/0", start_o, busy_o);
        end
        go = 1'b0;
        rst = 1'b0;
        b_exp = '0; p_exp = '0;
        tick();
        checks++;
        if (busy_o !== 1'b0 || start_o !== 1'b0) begin
            errors++; $display("FAIL no_restart got st=%b bz=%b want 0/0", start_o, busy_o);
        end
        start_run();
        nb = 0;
        b_pulse();
        checks++;
        if (b_o !== mb[0]) begin
            errors++; $display("FAIL restart_b0 got %h want %h", b_o, mb[0]);
        end
        finish_run();
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_addr = '0; wr_data = '0;
        go = 1'b0; a_shift = 1'b0; b_fetch = 1'b0; p_fetch = 1'b0;
        res_push = 1'b0; res_d = '0; done = 1'b0; rd_addr = '0;
        nb = 0; np = 0; b_exp = '0; p_exp = '0;
        test_reset();
        test_window();
        test_fetch();
        test_results();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fios_operand_server.md
FIOS_OPERAND_SERVER -- requirements
Module: fios_operand_server

Interface
REQ-001 Parameter s, default 8: operand/result length in 17-bit words.
REQ-002 Parameter PE_NB, default 8: number of a words presented in parallel per window.
REQ-003 clock_i  in  1  single clock, all state updates on its rising edge.
REQ-004 reset_i  in  1  reset, asynchronous, active-high.
REQ-005 wr_en_i / wr_sel_i[1:0] / wr_addr_i[$clog2(s)-1:0] / wr_data_i[16:0]  in  host operand write port; sel 0=A, 1=B, 2=P, 3=ignored.
REQ-006 go_i  in  1  host request to start one multiplication.
REQ-007 start_o  out  1  one-cycle start pulse to the multiplier.
REQ-008 a_o  out  PE_NB*17  current A window; word k occupies bits [17k+16:17k].
REQ-009 a_shift_i, b_fetch_i, p_fetch_i  in  1 each  multiplier requests: advance A window, next B word, next P word.
REQ-010 b_o[16:0], p_o[16:0]  out  B and P words returned to the multiplier.
REQ-011 RES_push_i  in  1  and RES_i[16:0]  in  result word strobe and data.
REQ-012 done_i  in  1  multiplier completion pulse.
REQ-013 rd_addr_i[$clog2(s)-1:0]  in  and rd_data_o[16:0]  out  host result read port.
REQ-014 busy_o, res_valid_o, err_o  out  1 each  status flags.

Function
REQ-015 FSM states IDLE, START, RUN, FIN; IDLE->START on go_i; START->RUN unconditionally; RUN->FIN on done_i; FIN->IDLE unconditionally.
REQ-016 start_o is 1 only in START; busy_o is 1 in START, RUN, FIN.
REQ-017 go_i outside IDLE is ignored; host writes with busy_o=1 are dropped.
REQ-018 In START: a_base, b_ptr, p_ptr, r_ptr clear to 0, res_valid_o clears, err_o clears.
REQ-019 a_o word k = A[a_base+k] when a_base+k < s, else 0; combinational from a_base and the A buffer.
REQ-020 a_shift_i in RUN: a_base += PE_NB; no wrap; window beyond s reads all zero.
REQ-021 b_fetch_i in RUN: b_o <= B[b_ptr] next cycle; b_ptr increments, wrapping s-1->0; b_o holds otherwise.
REQ-022 p_fetch_i: identical to REQ-021 for P/p_ptr/p_o; b and p fetches are independent and may coincide.
REQ-023 RES_push_i in RUN with r_ptr < s: R[r_ptr] <= RES_i, r_ptr++.
REQ-024 RES_push_i with r_ptr == s: overflow (see REQ-033).
REQ-025 RES_push_i and done_i in the same cycle: the word is written before FIN.
REQ-026 FIN sets res_valid_o=1; held until next START or reset.
REQ-027 rd_data_o <= R[rd_addr_i] every cycle, 1-cycle latency, valid any state.
REQ-028 Fetch, shift and push strobes outside RUN are ignored.

Reset
REQ-029 reset_i asserted: FSM->IDLE; start_o, busy_o, res_valid_o, err_o = 0; b_o, p_o, rd_data_o = 0; a_base, b_ptr, p_ptr, r_ptr = 0.
REQ-030 A, B, P, R buffer contents are not reset; reset mid-RUN abandons the operation with no further start_o.
REQ-031 Deassertion needs no sync handling inside the block; first state change occurs on the first edge after deassertion.

Configuration
REQ-032 Macro FIOS_SERVER_OVF_CHECK_EN selects overflow handling.
REQ-033 Defined: overflow push is dropped and err_o sets sticky (cleared only by START or reset).
REQ-034 Undefined: err_o tied 0; r_ptr wraps s-1->0 and the overflow push overwrites R[0].

Verification (s=8, PE_NB=4)
REQ-035 Load A=1..8, go_i -> start_o one cycle later for one cycle; a_o = {4,3,2,1}; after one a_shift_i = {8,7,6,5}; after two = 0.
REQ-036 B=0x10..0x17, 10 b_fetch_i pulses -> b_o sequence 0x10..0x17,0x10,0x11 one cycle after each pulse.
REQ-037 b_fetch_i and p_fetch_i together each cycle, P=0x20..0x27 -> b_o/p_o advance in lockstep with no lost words.
REQ-038 8 pushes RES=0xA0..0xA7 plus done_i on last -> res_valid_o=1 after FIN; rd_addr_i=7 gives 0xA7 next cycle.
REQ-039 9th push 0x1FFFF -> with macro: err_o=1, R[0]=0xA0; without: err_o=0, R[0]=0x1FFFF.
REQ-040 reset_i mid-RUN after 3 fetches -> all outputs 0 immediately; next go_i restarts with b_o=B[0] on first fetch.
